// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, IR field
// positions, FSM states and opcode classification helpers.
package alu_seq_pkg;

    localparam int unsigned OpWidth  = 5;
    localparam int unsigned RegWidth = 4;
    localparam int unsigned IrWidth  = 32;

    // MSB positions of the instruction fields within IR
    localparam int unsigned OpMsb = 31;
    localparam int unsigned RaMsb = 26;
    localparam int unsigned RbMsb = 22;
    localparam int unsigned RcMsb = 18;

    localparam logic [OpWidth-1:0] OpAdd  = 5'd0;
    localparam logic [OpWidth-1:0] OpSub  = 5'd1;
    localparam logic [OpWidth-1:0] OpAnd  = 5'd2;
    localparam logic [OpWidth-1:0] OpOr   = 5'd3;
    localparam logic [OpWidth-1:0] OpShr  = 5'd4;
    localparam logic [OpWidth-1:0] OpShra = 5'd5;
    localparam logic [OpWidth-1:0] OpShl  = 5'd6;
    localparam logic [OpWidth-1:0] OpRor  = 5'd7;
    localparam logic [OpWidth-1:0] OpRol  = 5'd8;
    localparam logic [OpWidth-1:0] OpNeg  = 5'd9;
    localparam logic [OpWidth-1:0] OpNot  = 5'd10;
    localparam logic [OpWidth-1:0] OpMul  = 5'd11;
    localparam logic [OpWidth-1:0] OpDiv  = 5'd12;

    typedef enum logic [3:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT4u,
        StT5l,
        StT6l
    } state_e;

    typedef enum logic [1:0] {
        ClsBinary,
        ClsUnary,
        ClsLong,
        ClsIllegal
    } op_class_e;

    function automatic logic is_binary(logic [OpWidth-1:0] op);
        return (op <= OpRol);
    endfunction

    function automatic logic is_unary(logic [OpWidth-1:0] op);
        return (op == OpNeg) || (op == OpNot);
    endfunction

    function automatic logic is_long(logic [OpWidth-1:0] op);
        return (op == OpMul) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational IR decoder: splits the instruction into opcode and register
// fields and classifies the opcode.
import alu_seq_pkg::*;

module alu_seq_decode #(
    parameter int unsigned OPW = OpWidth,
    parameter int unsigned RSW = RegWidth
) (
    input  logic [IrWidth-1:0] ir,
    output logic [OPW-1:0]     op,
    output logic [RSW-1:0]     ra,
    output logic [RSW-1:0]     rb,
    output logic [RSW-1:0]     rc,
    output op_class_e          op_class
);

    assign op = ir[OpMsb -: OPW];
    assign ra = ir[RaMsb -: RSW];
    assign rb = ir[RbMsb -: RSW];
    assign rc = ir[RcMsb -: RSW];

    // Low IR bits hold immediates for other instruction formats
    logic unused_ir;
    assign unused_ir = ^ir[RcMsb-RSW:0];

    always_comb begin
        op_class = ClsIllegal;
        if (is_binary(op)) begin
            op_class = ClsBinary;
        end else if (is_unary(op)) begin
            op_class = ClsUnary;
        end else if (is_long(op)) begin
            op_class = ClsLong;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM that fetches an instruction over the bus datapath
// and sequences register-to-register ALU execution through Y/Z/HI/LO.
import alu_seq_pkg::*;

module alu_sequencer #(
    parameter int unsigned OPW = OpWidth,
    parameter int unsigned RSW = RegWidth
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mem_ready,
    input  logic [IrWidth-1:0] ir,
    output logic               pc_out,
    output logic               mar_in,
    output logic               inc_pc,
    output logic               pc_in,
    output logic               read,
    output logic               mdr_in,
    output logic               mdr_out,
    output logic               ir_in,
    output logic               y_in,
    output logic               z_in,
    output logic               zlo_out,
    output logic               zhi_out,
    output logic               lo_in,
    output logic               hi_in,
    output logic               r_out,
    output logic               r_in,
    output logic [RSW-1:0]     r_sel,
    output logic [OPW-1:0]     alu_op,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    state_e         state_q, state_d;
    logic           t1_wait_q;
    logic [OPW-1:0] op;
    logic [RSW-1:0] ra, rb, rc;
    op_class_e      op_class;

    alu_seq_decode #(
        .OPW (OPW),
        .RSW (RSW)
    ) u_decode (
        .ir       (ir),
        .op       (op),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .op_class (op_class)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            t1_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Marks T1 repeat cycles so the PC reload happens only once
            t1_wait_q <= (state_q == StT1) && !mem_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   if (mem_ready) state_d = StT2;
            StT2:   state_d = StT3;
            StT3: begin
                case (op_class)
                    ClsBinary, ClsLong: state_d = StT4;
                    ClsUnary:           state_d = StT4u;
                    default:            state_d = StIdle;
                endcase
            end
            StT4:    state_d = (op_class == ClsLong) ? StT5l : StT5;
            StT5l:   state_d = StT6l;
            StT5, StT4u, StT6l: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_out  = 1'b0;
        mar_in  = 1'b0;
        inc_pc  = 1'b0;
        pc_in   = 1'b0;
        read    = 1'b0;
        mdr_in  = 1'b0;
        mdr_out = 1'b0;
        ir_in   = 1'b0;
        y_in    = 1'b0;
        z_in    = 1'b0;
        zlo_out = 1'b0;
        zhi_out = 1'b0;
        lo_in   = 1'b0;
        hi_in   = 1'b0;
        r_out   = 1'b0;
        r_in    = 1'b0;
        r_sel   = '0;
        alu_op  = '0;
        done    = 1'b0;
        illegal = 1'b0;
        busy    = (state_q != StIdle);
        case (state_q)
            StT0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            StT1: begin
                zlo_out = 1'b1;
                read    = 1'b1;
                mdr_in  = 1'b1;
                pc_in   = !t1_wait_q;
            end
            StT2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            StT3: begin
                case (op_class)
                    ClsBinary: begin
                        r_out = 1'b1;
                        r_sel = rb;
                        y_in  = 1'b1;
                    end
                    ClsLong: begin
                        r_out = 1'b1;
                        r_sel = ra;
                        y_in  = 1'b1;
                    end
                    ClsUnary: begin
                        r_out  = 1'b1;
                        r_sel  = rb;
                        alu_op = op;
                        z_in   = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            StT4: begin
                r_out  = 1'b1;
                r_sel  = (op_class == ClsLong) ? rb : rc;
                alu_op = op;
                z_in   = 1'b1;
            end
            StT5, StT4u: begin
                zlo_out = 1'b1;
                r_in    = 1'b1;
                r_sel   = ra;
                done    = 1'b1;
            end
            StT5l: begin
                zlo_out = 1'b1;
                lo_in   = 1'b1;
            end
            StT6l: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven bench for alu_sequencer: per-cycle expected strobes go to a
// scoreboard queue and are compared every cycle, plus latency and reset checks.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, r_out, r_in;
    logic [3:0]  r_sel;
    logic [4:0]  alu_op;
    logic        busy, done, illegal;

    alu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_ready (mem_ready),
        .ir        (ir),
        .pc_out    (pc_out),
        .mar_in    (mar_in),
        .inc_pc    (inc_pc),
        .pc_in     (pc_in),
        .read      (read),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .zlo_out   (zlo_out),
        .zhi_out   (zhi_out),
        .lo_in     (lo_in),
        .hi_in     (hi_in),
        .r_out     (r_out),
        .r_in      (r_in),
        .r_sel     (r_sel),
        .alu_op    (alu_op),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
        logic       y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, r_out, r_in;
        logic [3:0] r_sel;
        logic [4:0] alu_op;
        logic       busy, done, illegal;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        int          waits;
        int          lat;
        bit          start_at_done;
    } vec_t;

    outs_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;

    function automatic outs_t cur_outs();
        outs_t a;
        a = '{pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
              y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, r_out, r_in,
              r_sel, alu_op, busy, done, illegal};
        return a;
    endfunction

    function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
        logic [31:0] w;
        w = '0;
        w[31:27] = op[4:0];
        w[26:23] = ra[3:0];
        w[22:19] = rb[3:0];
        w[18:15] = rc[3:0];
        return w;
    endfunction

    // Every cycle: compare against the scoreboard head (idle zeros if empty)
    always @(posedge clk) begin
        outs_t a, e;
        #2;
        if (mon_en) begin
            a = cur_outs();
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs @%0t: got %h required %h", $time, a, e);
            end
            n_checks++;
            assert ($countones({pc_out, zlo_out, zhi_out, mdr_out, r_out}) <= 1)
            else begin
                n_fail++;
                $display("FAIL bus_exclusive @%0t: drivers %b required at most one",
                         $time, {pc_out, zlo_out, zhi_out, mdr_out, r_out});
            end
        end
    end

    task automatic push_expected(input logic [31:0] w, input int waits);
        outs_t      v;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = w[31:27];
        ra = w[26:23];
        rb = w[22:19];
        rc = w[18:15];
        v = '0; v.busy = 1; v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.z_in = 1;
        exp_q.push_back(v);
        for (int i = 0; i <= waits; i++) begin
            v = '0; v.busy = 1; v.zlo_out = 1; v.read = 1; v.mdr_in = 1; v.pc_in = (i == 0);
            exp_q.push_back(v);
        end
        v = '0; v.busy = 1; v.mdr_out = 1; v.ir_in = 1;
        exp_q.push_back(v);
        if (op <= 5'd8) begin
            v = '0; v.busy = 1; v.r_out = 1; v.r_sel = rb; v.y_in = 1;
            exp_q.push_back(v);
            v = '0; v.busy = 1; v.r_out = 1; v.r_sel = rc; v.alu_op = op; v.z_in = 1;
            exp_q.push_back(v);
            v = '0; v.busy = 1; v.zlo_out = 1; v.r_in = 1; v.r_sel = ra; v.done = 1;
            exp_q.push_back(v);
        end else if (op == 5'd9 || op == 5'd10) begin
            v = '0; v.busy = 1; v.r_out = 1; v.r_sel = rb; v.alu_op = op; v.z_in = 1;
            exp_q.push_back(v);
            v = '0; v.busy = 1; v.zlo_out = 1; v.r_in = 1; v.r_sel = ra; v.done = 1;
            exp_q.push_back(v);
        end else if (op == 5'd11 || op == 5'd12) begin
            v = '0; v.busy = 1; v.r_out = 1; v.r_sel = ra; v.y_in = 1;
            exp_q.push_back(v);
            v = '0; v.busy = 1; v.r_out = 1; v.r_sel = rb; v.alu_op = op; v.z_in = 1;
            exp_q.push_back(v);
            v = '0; v.busy = 1; v.zlo_out = 1; v.lo_in = 1;
            exp_q.push_back(v);
            v = '0; v.busy = 1; v.zhi_out = 1; v.hi_in = 1; v.done = 1;
            exp_q.push_back(v);
        end else begin
            v = '0; v.busy = 1; v.illegal = 1;
            exp_q.push_back(v);
        end
    endtask

    task automatic run_instr(input vec_t t);
        int cnt;
        int t1;
        int budget;
        @(negedge clk);
        ir        = t.ir;
        mem_ready = (t.waits == 0);
        push_expected(t.ir, t.waits);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cnt    = 0;
        t1     = 0;
        budget = 0;
        while (budget < 60) begin
            if (busy) cnt++;
            if (read) begin
                t1++;
                mem_ready = (t1 > t.waits);
            end
            start = done && t.start_at_done;
            if (!busy) break;
            @(negedge clk);
            budget++;
        end
        start     = 1'b0;
        mem_ready = 1'b1;
        n_checks++;
        if (budget >= 60) begin
            n_fail++;
            $display("FAIL timeout_%s: busy still %b after %0d cycles, required 0", t.name,
                     busy, budget);
        end else if (cnt != t.lat) begin
            n_fail++;
            $display("FAIL latency_%s: got %0d busy cycles, required %0d", t.name, cnt, t.lat);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: %0d expected cycles left, required 0", t.name, exp_q.size());
            exp_q.delete();
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"add_r1_r2_r3", 32'h0091_8000, 0, 6, 1'b0};
        vecs[1] = '{"not_r5_r6",    32'h52B0_0000, 0, 5, 1'b0};
        vecs[2] = '{"mul_r2_r4",    32'h5920_0000, 0, 7, 1'b0};
        vecs[3] = '{"add_wait3",    32'h0091_8000, 3, 9, 1'b0};
        vecs[4] = '{"illegal_31",   32'hF800_0000, 0, 4, 1'b0};
        vecs[5] = '{"rol_start_done", mk(8, 7, 8, 9), 0, 6, 1'b1};
        vecs[6] = '{"neg_r15_r0",   mk(9, 15, 0, 0), 0, 5, 1'b0};
        vecs[7] = '{"div_wait1",    mk(12, 3, 14, 0), 1, 8, 1'b1};
        vecs[8] = '{"illegal_13",   mk(13, 1, 2, 3), 2, 6, 1'b0};
        vecs[9] = '{"sub_r10_r11_r12", mk(1, 10, 11, 12), 0, 6, 1'b0};

        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b1;
        ir        = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (cur_outs() !== outs_t'('0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h required 0", cur_outs());
        end
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) run_instr(vecs[i]);

        // Reset during T4 of ADD: outputs drop without a clock edge
        @(negedge clk);
        ir = 32'h0091_8000;
        push_expected(ir, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (!(z_in && r_sel == 4'd3 && alu_op == 5'd0 && r_out)) begin
            n_fail++;
            $display("FAIL pre_reset_t4: z_in=%b r_out=%b r_sel=%0d required 1 1 3", z_in,
                     r_out, r_sel);
        end
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        n_checks++;
        if (cur_outs() !== outs_t'('0)) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 0", cur_outs());
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        run_instr(vecs[0]);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
